// File: rtl/impl_responder.sv
// Fixed-latency request/response pipe: echoes a_data on b/b_data DELAY+1 edges after acceptance.
// Latency: a request accepted at posedge k shows b=1 in the cycle after posedge k+DELAY.
// Backpressure: none; a new request can enter every cycle, and requests seen with en low are dropped.
module impl_responder #(
  parameter int DELAY = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         a,
  input  logic [W-1:0] a_data,
  output logic         b,
  output logic [W-1:0] b_data,
  output logic         busy,
  output logic [7:0]   req_cnt,
  output logic [7:0]   rsp_cnt,
  output logic [7:0]   drop_cnt
);

  logic [DELAY-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DELAY];
  logic [W-1:0]     dat_d [DELAY];
  logic             b_q, b_d;
  logic [W-1:0]     b_data_q, b_data_d;
  logic [7:0]       req_cnt_q, req_cnt_d;
  logic [7:0]       rsp_cnt_q, rsp_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic accept;
  logic reject;

  assign accept = a & en;
  assign reject = a & ~en;

  // Next state: shift the valid/data pipe, load the output stage, and bump the saturating counters.
  // Payload bits are zeroed in empty stages, so b_data falls to zero whenever b is low.
  always_comb begin
    vld_d      = '0;
    for (int i = 0; i < DELAY; i++) dat_d[i] = '0;
    b_d        = 1'b0;
    b_data_d   = '0;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    drop_cnt_d = drop_cnt_q;

    vld_d[0] = accept;
    dat_d[0] = accept ? a_data : '0;
    for (int i = 1; i < DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end

    b_d      = vld_q[DELAY-1];
    b_data_d = vld_q[DELAY-1] ? dat_q[DELAY-1] : '0;

    if (accept && req_cnt_q != 8'hFF)  req_cnt_d  = req_cnt_q + 8'd1;
    if (b_d && rsp_cnt_q != 8'hFF)     rsp_cnt_d  = rsp_cnt_q + 8'd1;
    if (reject && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // State registers; a synchronous reset flushes in-flight requests and clears every counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      for (int i = 0; i < DELAY; i++) dat_q[i] <= '0;
      b_q        <= 1'b0;
      b_data_q   <= '0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      for (int i = 0; i < DELAY; i++) dat_q[i] <= dat_d[i];
      b_q        <= b_d;
      b_data_q   <= b_data_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign b        = b_q;
  assign b_data   = b_data_q;
  assign busy     = |vld_q;
  assign req_cnt  = req_cnt_q;
  assign rsp_cnt  = rsp_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_impl_responder.sv
// Scoreboard bench for impl_responder: DELAY=2 and DELAY=1 instances share one stimulus stream.
// Expected responses are queued with the cycle they are due in; negedge monitors pop and compare.
// Counter and busy values come from hand-computed constants for each directed scenario.
module tb_impl_responder;

  typedef struct {
    logic [7:0] dat;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       a = 1'b0;
  logic [7:0] a_data = 8'h00;

  logic       b_v    [2];
  logic [7:0] bd_v   [2];
  logic       busy_v [2];
  logic [7:0] req_v  [2];
  logic [7:0] rsp_v  [2];
  logic [7:0] drop_v [2];

  exp_t q [2][$];
  int   dl [2] = '{2, 1};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  impl_responder #(.DELAY(2), .W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .a_data(a_data),
    .b(b_v[0]), .b_data(bd_v[0]), .busy(busy_v[0]),
    .req_cnt(req_v[0]), .rsp_cnt(rsp_v[0]), .drop_cnt(drop_v[0])
  );

  impl_responder #(.DELAY(1), .W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .a_data(a_data),
    .b(b_v[1]), .b_data(bd_v[1]), .busy(busy_v[1]),
    .req_cnt(req_v[1]), .rsp_cnt(rsp_v[1]), .drop_cnt(drop_v[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive inputs 2 time units after a posedge; they are sampled at the following posedge.
  task automatic step(input logic r, input logic e, input logic av, input logic [7:0] d);
    exp_t x;
    @(posedge clk);
    #2;
    rst_n  = r;
    en     = e;
    a      = av;
    a_data = d;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        while (q[i].size() > 0 && q[i][$].due > cyc) void'(q[i].pop_back());
      end else if (av && e) begin
        x.dat = d;
        x.due = cyc + 1 + dl[i];
        q[i].push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_cnt(input string nm, input int rq, input int rs, input int dr);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s req_cnt d%0d", nm, dl[i]), req_v[i], rq);
      chk($sformatf("%s rsp_cnt d%0d", nm, dl[i]), rsp_v[i], rs);
      chk($sformatf("%s drop_cnt d%0d", nm, dl[i]), drop_v[i], dr);
    end
  endtask

  // Monitor: every cycle b either matches the head of the queue in data and due cycle, or is idle with zero payload.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        while (q[i].size() > 0 && q[i][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rsp d%0d: no b for data %0h due cycle %0d", dl[i], q[i][0].dat, q[i][0].due);
          void'(q[i].pop_front());
        end
        if (b_v[i] === 1'b1) begin
          if (q[i].size() > 0 && q[i][0].due == cyc) begin
            chk($sformatf("b_data d%0d", dl[i]), bd_v[i], q[i][0].dat);
            void'(q[i].pop_front());
          end else begin
            chk($sformatf("unexpected_b d%0d", dl[i]), 1, 0);
          end
        end else begin
          chk($sformatf("b_known d%0d", dl[i]), b_v[i], 0);
          chk($sformatf("idle_b_data d%0d", dl[i]), bd_v[i], 0);
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    mon_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst b d%0d", dl[i]), b_v[i], 0);
      chk($sformatf("rst busy d%0d", dl[i]), busy_v[i], 0);
    end
    chk_cnt("rst", 0, 0, 0);

    // Single request, issued at the first posedge after reset release
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("busy p1 d2", busy_v[0], 1);
    chk("busy p1 d1", busy_v[1], 1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("busy p2 d2", busy_v[0], 1);
    chk("busy p2 d1", busy_v[1], 0);
    chk("b p2 d2", b_v[0], 0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("busy p3 d2", busy_v[0], 0);
    chk("b p3 d2", b_v[0], 1);
    chk("b_data p3 d2", bd_v[0], 8'hA5);
    idle(4);
    chk_cnt("single", 1, 1, 0);

    // Back-to-back requests
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 1'b1, k[7:0]);
    idle(6);
    chk_cnt("b2b", 4, 4, 0);

    // Enable gating
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h5A);
    idle(6);
    chk_cnt("gate", 0, 0, 1);

    // en dropped after acceptance
    do_reset();
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("late_en b d2", b_v[0], 1);
    idle(4);
    chk_cnt("late_en", 1, 1, 0);

    // Reset mid-flight, with a asserted during reset
    do_reset();
    step(1'b1, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b0, 1'b1, 8'h33);
    idle(7);
    chk_cnt("midrst", 0, 0, 0);

    // Saturation
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b1, k[7:0]);
    idle(6);
    chk_cnt("sat_acc", 255, 255, 0);
    for (int k = 0; k < 260; k++) step(1'b1, 1'b0, 1'b1, k[7:0]);
    idle(2);
    chk_cnt("sat_drop", 255, 255, 255);

    idle(3);
    chk("queue_empty d2", q[0].size(), 0);
    chk("queue_empty d1", q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
